regfile_mp: RTL

Parametrised multi-port integer register file for the RISC-V datapath. It is the successor to the current fixed 32×32 two-read register unit and adds:
- configurable width, depth and read-port count
- optional write-to-read bypass
- asynchronous reset of the whole array
- a handshaked sequential dump channel that streams every register to the VGA debug display, replacing the flat 32-word wire bundle

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_dump_fsm.sv | 84 ++++++++
 rtl/regfile_mp.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and helpers for the multi-port register file
package regfile_pkg;

    // Dump channel sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_t;

    // Architectural zero register index
    localparam int REG_ZERO = 0;

    // Address width needed to index n registers
    function automatic int reg_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - sequential register dump state machine with valid/ready handshake
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = reg_aw(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_req,
    input  logic            dump_ready,
    input  logic [XLEN-1:0] arr_data,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,
    output logic            dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          in_stream;
    logic          beat_xfer;
    logic          at_last;

    assign in_stream = (state_q == STREAM);
    assign at_last   = in_stream && (idx_q == LAST_IDX);
    assign beat_xfer = in_stream && dump_ready;

    // State and index registers; reset aborts any dump in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: the index stops at the last register instead of wrapping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (beat_xfer) begin
                    if (at_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_busy  = (state_q != IDLE);
    assign dump_valid = in_stream;
    assign dump_idx   = idx_q;
    assign dump_last  = at_last;
    assign dump_done  = (state_q == DONE);
    // Data is the live array contents at the current index, not a snapshot
    assign dump_data  = arr_data;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass and debug dump channel
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = reg_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AW-1:0]     dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_last,
    output logic              dump_done
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] dump_arr_data;
    logic            wr_nonzero;

    // Writes to the zero register are dropped everywhere, including bypass
    assign wr_nonzero = we && (wr_addr != AW'(REG_ZERO));

    for (genvar g = 0; g < NREGS; g++) begin : gen_reg
        if (g == REG_ZERO) begin : gen_zero
            assign regs[g] = '0;
        end else begin : gen_flop
            logic [XLEN-1:0] reg_q, reg_d;

            // Load new data only when this register is the write target
            always_comb begin
                reg_d = reg_q;
                if (wr_nonzero && (wr_addr == AW'(g))) begin
                    reg_d = wr_data;
                end
            end

            // Storage element, cleared asynchronously with the whole array
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[g] = reg_q;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : gen_rd
        logic [AW-1:0] addr;
        logic          byp_hit;

        assign addr    = rd_addr[k*AW +: AW];
        assign byp_hit = (BYPASS != 0) && wr_nonzero && (wr_addr == addr);
        assign rd_data[k*XLEN +: XLEN] = byp_hit ? wr_data : regs[addr];
    end

    // Dedicated mux for the dump index so read ports are never disturbed
    assign dump_arr_data = regs[dump_idx];

    regfile_dump_fsm #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .arr_data   (dump_arr_data),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_done  (dump_done)
    );

endmodule
